// File: rtl/md_word_packer.sv
// md_word_packer: packs MD byte-lane transfers into full words via an output FIFO.
// Define MD_PACKER_BSWAP_EN to present word_data byte-reversed.
module md_word_packer #(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0]             md_rx_data,
  input  logic [$clog2(ALGN_DATA_WIDTH/8)-1:0]   md_rx_offset,
  input  logic [$clog2(ALGN_DATA_WIDTH/8):0]     md_rx_size,
  output logic                                   md_rx_ready,
  output logic                                   md_rx_err,
  input  logic                                   flush,
  output logic                                   word_valid,
  output logic [ALGN_DATA_WIDTH-1:0]             word_data,
  output logic [$clog2(ALGN_DATA_WIDTH/8):0]     word_bytes,
  input  logic                                   word_ready,
  output logic [$clog2(FIFO_DEPTH):0]            fill_level,
  output logic [7:0]                             drop_cnt
);

  localparam int W  = ALGN_DATA_WIDTH;
  localparam int NB = W / 8;
  localparam int SW = $clog2(NB) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [SW-1:0] NB_C   = SW'(NB);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FLUSH_PEND
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [7:0]      drop_q, drop_d;
  logic [CW-1:0]   fill_q;
  logic [PW-1:0]   wr_q, rd_q;
  logic [W-1:0]    mem_data_q [FIFO_DEPTH];
  logic [SW-1:0]   mem_bytes_q [FIFO_DEPTH];

  logic            legal, accept, push, pop, full;
  logic [W-1:0]    shifted, dsel, push_data, head;
  logic [2*W-1:0]  merged;
  logic [SW-1:0]   total, push_bytes;

  assign full  = (fill_q == DEPTH_C);
  assign legal = (md_rx_size != '0) &&
                 ((SW+1)'(md_rx_offset) + (SW+1)'(md_rx_size)
                  <= (SW+1)'(NB));
  assign md_rx_err   = md_rx_valid & ~legal;
  assign md_rx_ready = (fill_q < DEPTH_C) & ~flush &
                       (state_q != S_FLUSH_PEND);
  assign accept  = md_rx_valid & md_rx_ready;
  assign shifted = md_rx_data >> {md_rx_offset, 3'b000};
  assign total   = cnt_q + md_rx_size;

  always_comb begin
    dsel = '0;
    for (int b = 0; b < NB; b++) begin
      if (SW'(b) < md_rx_size) dsel[b*8 +: 8] = shifted[b*8 +: 8];
    end
  end

  // accumulator is kept zero above lane cnt_q, so OR-merging is safe
  assign merged = {{W{1'b0}}, acc_q} |
                  ({{W{1'b0}}, dsel} << {cnt_q, 3'b000});

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    push       = 1'b0;
    push_data  = acc_q;
    push_bytes = cnt_q;
    unique case (state_q)
      S_FLUSH_PEND: begin
        if (!full) begin
          push    = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_EMPTY;
        end
      end
      default: begin
        if (flush && state_q == S_PARTIAL) begin
          state_d = S_FLUSH_PEND;
        end else if (accept && !legal) begin
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end else if (accept) begin
          if (total >= NB_C) begin
            push       = 1'b1;
            push_data  = merged[W-1:0];
            push_bytes = NB_C;
            acc_d      = merged[2*W-1:W];
            cnt_d      = total - NB_C;
          end else begin
            acc_d = merged[W-1:0];
            cnt_d = total;
          end
          state_d = (cnt_d == '0) ? S_EMPTY : S_PARTIAL;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  assign pop = word_valid & word_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_q]  <= push_data;
      mem_bytes_q[wr_q] <= push_bytes;
    end
  end

  assign head = mem_data_q[rd_q];

  always_comb begin
    word_data = '0;
    if (word_valid) begin
`ifdef MD_PACKER_BSWAP_EN
      for (int b = 0; b < NB; b++) begin
        word_data[b*8 +: 8] = head[(NB-1-b)*8 +: 8];
      end
`else
      word_data = head;
`endif
    end
  end

  assign word_valid = (fill_q != '0);
  assign word_bytes = word_valid ? mem_bytes_q[rd_q] : '0;
  assign fill_level = fill_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_md_word_packer.sv
// Directed bench for md_word_packer (default build, 32-bit words, depth 4).
module tb_md_word_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        md_rx_valid;
  logic [31:0] md_rx_data;
  logic [1:0]  md_rx_offset;
  logic [2:0]  md_rx_size;
  logic        md_rx_ready;
  logic        md_rx_err;
  logic        flush;
  logic        word_valid;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
  logic        word_ready;
  logic [2:0]  fill_level;
  logic [7:0]  drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  md_word_packer #(.ALGN_DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .md_rx_valid  (md_rx_valid),
    .md_rx_data   (md_rx_data),
    .md_rx_offset (md_rx_offset),
    .md_rx_size   (md_rx_size),
    .md_rx_ready  (md_rx_ready),
    .md_rx_err    (md_rx_err),
    .flush        (flush),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .word_bytes   (word_bytes),
    .word_ready   (word_ready),
    .fill_level   (fill_level),
    .drop_cnt     (drop_cnt)
  );

  task automatic send(input logic [1:0] off, input logic [2:0] sz,
                      input logic [31:0] d, output logic err);
    int n;
    md_rx_offset = off;
    md_rx_size   = sz;
    md_rx_data   = d;
    md_rx_valid  = 1'b1;
    #1;
    n = 0;
    while (!md_rx_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!md_rx_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: ready=%b want 1", md_rx_ready);
    end
    err = md_rx_err;
    @(posedge clk); #1;
    md_rx_valid = 1'b0;
  endtask

  task automatic pop1();
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; md_rx_valid = 1'b0; md_rx_data = '0;
    md_rx_offset = '0; md_rx_size = '0; flush = 1'b0; word_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (word_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_valid: got %b want 0", word_valid); end
    n_chk++; if (md_rx_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_ready: got %b want 1", md_rx_ready); end
    n_chk++; if (fill_level !== 3'd0) begin n_fail++;
      $display("FAIL rst_fill: got %0d want 0", fill_level); end
    n_chk++; if (drop_cnt !== 8'd0) begin n_fail++;
      $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    n_chk++; if (md_rx_err !== 1'b0) begin n_fail++;
      $display("FAIL rst_err: got %b want 0", md_rx_err); end
    n_chk++; if (word_data !== 32'h0) begin n_fail++;
      $display("FAIL rst_data: got %h want 0", word_data); end
    n_chk++; if (word_bytes !== 3'd0) begin n_fail++;
      $display("FAIL rst_bytes: got %0d want 0", word_bytes); end
  endtask

  task automatic test_pack_bytes();
    logic e;
    send(2'd0, 3'd1, 32'h0000_0011, e);
    send(2'd1, 3'd1, 32'h0000_2200, e);
    send(2'd2, 3'd1, 32'h0033_0000, e);
    n_chk++; if (word_valid !== 1'b0) begin n_fail++;
      $display("FAIL pack_early: valid=%b want 0", word_valid); end
    send(2'd3, 3'd1, 32'h4400_0000, e);
    n_chk++; if (word_valid !== 1'b1) begin n_fail++;
      $display("FAIL pack_valid: got %b want 1", word_valid); end
    n_chk++; if (word_data !== 32'h4433_2211) begin n_fail++;
      $display("FAIL pack_data: got %h want 44332211", word_data); end
    n_chk++; if (word_bytes !== 3'd4) begin n_fail++;
      $display("FAIL pack_bytes: got %0d want 4", word_bytes); end
    n_chk++; if (fill_level !== 3'd1) begin n_fail++;
      $display("FAIL pack_fill: got %0d want 1", fill_level); end
    pop1();
    n_chk++; if (fill_level !== 3'd0) begin n_fail++;
      $display("FAIL pack_pop: fill=%0d want 0", fill_level); end
  endtask

  task automatic test_partial_flush();
    logic e;
    send(2'd1, 3'd3, 32'hAABB_CC00, e);
    send(2'd0, 3'd2, 32'h0000_EEDD, e);
    n_chk++; if (word_data !== 32'hDDAA_BBCC) begin n_fail++;
      $display("FAIL pf_word: got %h want ddaabbcc", word_data); end
    n_chk++; if (word_bytes !== 3'd4) begin n_fail++;
      $display("FAIL pf_bytes: got %0d want 4", word_bytes); end
    pop1();
    pulse_flush();
    n_chk++; if (md_rx_ready !== 1'b0) begin n_fail++;
      $display("FAIL pf_pend_ready: got %b want 0", md_rx_ready); end
    @(posedge clk); #1;
    n_chk++; if (word_valid !== 1'b1 || word_data !== 32'h0000_00EE) begin
      n_fail++;
      $display("FAIL pf_flush_word: v=%b d=%h want 1 000000ee",
               word_valid, word_data); end
    n_chk++; if (word_bytes !== 3'd1) begin n_fail++;
      $display("FAIL pf_flush_bytes: got %0d want 1", word_bytes); end
    n_chk++; if (md_rx_ready !== 1'b1) begin n_fail++;
      $display("FAIL pf_ready_back: got %b want 1", md_rx_ready); end
    pop1();
    pulse_flush();
    repeat (3) @(posedge clk); #1;
    n_chk++; if (word_valid !== 1'b0) begin n_fail++;
      $display("FAIL pf_empty_flush: valid=%b want 0", word_valid); end
    send(2'd0, 3'd4, 32'h0102_0304, e);
    n_chk++; if (word_data !== 32'h0102_0304) begin n_fail++;
      $display("FAIL pf_acc_clear: got %h want 01020304", word_data); end
    pop1();
  endtask

  task automatic test_illegal();
    logic e;
    send(2'd0, 3'd1, 32'h0000_005A, e);
    send(2'd2, 3'd3, 32'h1234_5678, e);
    n_chk++; if (e !== 1'b1) begin n_fail++;
      $display("FAIL ill_err_span: got %b want 1", e); end
    send(2'd0, 3'd0, 32'h1234_5678, e);
    n_chk++; if (e !== 1'b1) begin n_fail++;
      $display("FAIL ill_err_zero: got %b want 1", e); end
    n_chk++; if (drop_cnt !== 8'd2) begin n_fail++;
      $display("FAIL ill_drop: got %0d want 2", drop_cnt); end
    n_chk++; if (word_valid !== 1'b0) begin n_fail++;
      $display("FAIL ill_noword: valid=%b want 0", word_valid); end
    send(2'd0, 3'd3, 32'h00C3_B2A1, e);
    n_chk++; if (e !== 1'b0) begin n_fail++;
      $display("FAIL ill_err_legal: got %b want 0", e); end
    n_chk++; if (word_data !== 32'hC3B2_A15A) begin n_fail++;
      $display("FAIL ill_acc_kept: got %h want c3b2a15a", word_data); end
    pop1();
  endtask

  task automatic test_back_to_back();
    logic e;
    logic acc;
    int got5;
    for (int k = 1; k <= 4; k++) send(2'd0, 3'd4, 32'(k), e);
    n_chk++; if (fill_level !== 3'd4) begin n_fail++;
      $display("FAIL b2b_fill: got %0d want 4", fill_level); end
    md_rx_offset = 2'd0; md_rx_size = 3'd4;
    md_rx_data = 32'h5; md_rx_valid = 1'b1;
    repeat (3) @(posedge clk); #1;
    n_chk++; if (md_rx_ready !== 1'b0) begin n_fail++;
      $display("FAIL b2b_stall: ready=%b want 0", md_rx_ready); end
    got5 = 0;
    for (int k = 1; k <= 5; k++) begin
      n_chk++;
      if (word_valid !== 1'b1 || word_data !== 32'(k)) begin n_fail++;
        $display("FAIL b2b_order%0d: v=%b d=%h want %h",
                 k, word_valid, word_data, 32'(k)); end
      word_ready = 1'b1;
      acc = md_rx_valid & md_rx_ready;
      @(posedge clk); #1;
      word_ready = 1'b0;
      if (acc) begin md_rx_valid = 1'b0; got5++; end
    end
    md_rx_valid = 1'b0;
    n_chk++; if (got5 !== 1) begin n_fail++;
      $display("FAIL b2b_accept5: got %0d want 1", got5); end
    n_chk++; if (md_rx_ready !== 1'b1 || fill_level !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_drain: ready=%b fill=%0d want 1 0",
               md_rx_ready, fill_level); end
  endtask

  task automatic test_flush_full();
    logic e;
    logic [31:0] exp_d [4] = '{32'h0605_0403, 32'h0A09_0807,
                               32'h0E0D_0C0B, 32'h0000_100F};
    logic [2:0]  exp_b [4] = '{3'd4, 3'd4, 3'd4, 3'd2};
    send(2'd0, 3'd2, 32'h0000_BEEF, e);
    send(2'd0, 3'd4, 32'h0403_0201, e);
    send(2'd0, 3'd4, 32'h0807_0605, e);
    send(2'd0, 3'd4, 32'h0C0B_0A09, e);
    send(2'd0, 3'd4, 32'h100F_0E0D, e);
    n_chk++; if (fill_level !== 3'd4 || word_data !== 32'h0201_BEEF) begin
      n_fail++;
      $display("FAIL ff_full: fill=%0d d=%h want 4 0201beef",
               fill_level, word_data); end
    pulse_flush();
    repeat (2) @(posedge clk); #1;
    n_chk++; if (md_rx_ready !== 1'b0 || fill_level !== 3'd4) begin
      n_fail++;
      $display("FAIL ff_hold: ready=%b fill=%0d want 0 4",
               md_rx_ready, fill_level); end
    pop1();
    n_chk++; if (md_rx_ready !== 1'b0 || fill_level !== 3'd3) begin
      n_fail++;
      $display("FAIL ff_pend: ready=%b fill=%0d want 0 3",
               md_rx_ready, fill_level); end
    @(posedge clk); #1;
    n_chk++; if (fill_level !== 3'd4) begin n_fail++;
      $display("FAIL ff_pushed: fill=%0d want 4", fill_level); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (word_data !== exp_d[i] || word_bytes !== exp_b[i]) begin
        n_fail++;
        $display("FAIL ff_word%0d: d=%h b=%0d want %h %0d",
                 i, word_data, word_bytes, exp_d[i], exp_b[i]); end
      pop1();
    end
    n_chk++; if (md_rx_ready !== 1'b1 || fill_level !== 3'd0) begin
      n_fail++;
      $display("FAIL ff_drain: ready=%b fill=%0d want 1 0",
               md_rx_ready, fill_level); end
  endtask

  task automatic test_reset_discard();
    logic e;
    send(2'd0, 3'd2, 32'h0000_CAFE, e);
    reset_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    pulse_flush();
    repeat (3) @(posedge clk); #1;
    n_chk++; if (word_valid !== 1'b0 || fill_level !== 3'd0) begin
      n_fail++;
      $display("FAIL rd_nopartial: v=%b fill=%0d want 0 0",
               word_valid, fill_level); end
    send(2'd0, 3'd4, 32'hDDCC_BBAA, e);
    n_chk++; if (word_data !== 32'hDDCC_BBAA || word_bytes !== 3'd4) begin
      n_fail++;
      $display("FAIL rd_fresh: d=%h b=%0d want ddccbbaa 4",
               word_data, word_bytes); end
    pop1();
  endtask

  initial begin
    test_reset();
    test_pack_bytes();
    test_partial_flush();
    test_illegal();
    test_back_to_back();
    test_flush_full();
    test_reset_discard();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/md_word_packer.md
Name: md_word_packer

Overview:
- Downstream stage of the aligner. Consumes the aligner's MD TX stream: valid/ready handshake, one byte-lane chunk per transfer.
- Packs the valid bytes of consecutive transfers contiguously into full ALGN_DATA_WIDTH words.
- Emits packed words through a small output FIFO on a valid/ready word port.
- An external flush pushes out a partially filled word.

Parameters:
- ALGN_DATA_WIDTH, 32: MD data width in bits. Multiple of 8 and at least 16. NB = ALGN_DATA_WIDTH/8.
- FIFO_DEPTH, 4: output word FIFO depth. Power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- md_rx_valid  in  1  MD transfer valid (from aligner md_tx_valid).
- md_rx_data  in  ALGN_DATA_WIDTH  MD data, byte lanes.
- md_rx_offset  in  $clog2(NB)  first valid byte lane.
- md_rx_size  in  $clog2(NB)+1  number of valid bytes.
- md_rx_ready  out  1  transfer accepted when valid & ready.
- md_rx_err  out  1  transfer illegal; meaningful only during the handshake cycle.
- flush  in  1  single-cycle pulse: emit the partial word.
- word_valid  out  1  output FIFO non-empty.
- word_data  out  ALGN_DATA_WIDTH  FIFO head data.
- word_bytes  out  $clog2(NB)+1  valid bytes in the head word, lanes 0..word_bytes-1.
- word_ready  in  1  head popped when valid & ready.
- fill_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- drop_cnt  out  8  illegal transfers dropped; saturates at 255.

Behaviour:
- Reset (asynchronous, reset_n low):
  - FIFO emptied, accumulator cleared (acc_cnt = 0), flush_pend = 0, drop_cnt = 0.
  - Outputs: word_valid = 0, word_data = 0, word_bytes = 0, fill_level = 0, md_rx_ready = 1, md_rx_err = 0.
  - Reset mid-accumulation discards partial bytes. Nothing is emitted for them after reset.
- Legality: a transfer is legal iff size != 0 and offset + size <= NB.
  - md_rx_err is combinational: md_rx_valid & ~legal.
  - An illegal transfer is still handshaken (ready rules apply), discarded, and increments drop_cnt (saturating).
- Byte order is little-endian. The first accumulated byte goes to lane 0 (bits 7:0).
  - A legal transfer appends md_rx_data[offset*8 +: size*8] at accumulator lane acc_cnt.
- Word completion:
  - If acc_cnt + size >= NB, the lower NB bytes are pushed to the FIFO with word_bytes = NB.
  - The remaining acc_cnt + size - NB bytes shift to lane 0 and become the new acc_cnt.
  - Otherwise acc_cnt += size.
  - A transfer produces at most one word.
- Accumulator FSM:
  - EMPTY (acc_cnt = 0): a legal transfer goes to PARTIAL, or stays EMPTY if it exactly completes a word.
  - PARTIAL (0 < acc_cnt < NB): completion with remainder 0 goes to EMPTY.
  - FLUSH_PEND is entered on flush while in PARTIAL.
  - FLUSH_PEND: md_rx_ready = 0. When the FIFO is not full, push {acc, word_bytes = acc_cnt}, clear the accumulator, go to EMPTY.
  - flush in EMPTY is a no-op; no zero-byte word is ever emitted.
- Flush in the same cycle as a valid transfer:
  - md_rx_ready is forced 0 that cycle, so the transfer is not accepted and flush is registered first.
  - The transfer is accepted after the flush completes.
- md_rx_ready = (fill_level < FIFO_DEPTH) & ~flush & (state != FLUSH_PEND).
  - No full-FIFO bypass: a pop in the same cycle does not raise ready.
- FIFO:
  - Push and pop in the same cycle are both performed; fill_level is unchanged.
  - Latency: a word completed on handshake edge N is visible at word_valid/word_data after edge N, i.e. one cycle.
  - Words leave in push order.
  - Pointers wrap modulo FIFO_DEPTH.
  - word_data and word_bytes hold stable while word_valid & ~word_ready.

Optional Feature:
- Macro MD_PACKER_BSWAP_EN.
- Defined: word_data is presented byte-reversed (lane 0 appears in the MSB byte). A partial word is reversed over all NB lanes, so its valid bytes occupy the top word_bytes lanes.
- Undefined: little-endian lane order as specified above. Ports are identical either way.

Test Plan:
- Reset, W=32: hold reset_n low 5 cycles, then release.
  -> word_valid=0, md_rx_ready=1, fill_level=0, drop_cnt=0, md_rx_err=0.
- Four size-1 transfers at offsets 0..3 carrying bytes 0x11, 0x22, 0x33, 0x44 in their lanes.
  -> one cycle after the 4th handshake: word_valid=1, word_data=0x44332211, word_bytes=4.
- Transfer offset=1 size=3 data=0xAABBCC00, then offset=0 size=2 data=0x0000EEDD.
  -> word 0x DDAABBCC, bytes=4.
  -> then flush pulse -> word 0x000000EE, bytes=1; acc_cnt returns to 0.
- Illegal transfers: offset=2 size=3, then size=0.
  -> md_rx_err=1 in both handshake cycles, drop_cnt=2, no word produced, accumulator unchanged.
- word_ready=0, five size-4 offset-0 transfers 0x00000001..0x00000005.
  -> md_rx_ready=0 after the 4th (fill_level=4), 5th stalled.
  -> raise word_ready: words 1..5 emerge in order, ready returns.
- Accumulate 2 bytes, flush with FIFO full.
  -> FLUSH_PEND holds ready=0 until a pop, then partial word bytes=2.
  -> separately, asserting reset_n low with 2 bytes accumulated leaves no partial word after reset.
